uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmit path: a write-side FIFO feeding a serialiser with runtime-selectable parity and stop-bit count. Generalises the existing transmitter top in data width, FIFO depth and oversampling ratio, and adds parity, two-stop-bit mode, occupancy and overflow reporting. Sits between the host write interface and the tx pin, and shares the baud-rate generator's s_tick with the receiver.

Parameters:
N_BIT, 8, data bits per frame and FIFO word width (legal 5..8)
ADDR_W, 2, FIFO address width; depth = 2**ADDR_W
OVS, 16, s_tick pulses per bit period (legal >= 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
s_tick  in  1  oversampling tick, one clk wide
tx_wr_data  in  N_BIT  word to enqueue
tx_wr_en  in  1  enqueue strobe
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none (reserved)
stop2  in  1  0 = one stop bit, 1 = two stop bits
tx  out  1  serial line, idle high
tx_full  out  1  FIFO full
tx_empty  out  1  FIFO empty
tx_count  out  ADDR_W+1  FIFO occupancy, 0..2**ADDR_W
tx_busy  out  1  high while a frame is in progress (state != IDLE)
tx_done_tick  out  1  one-clk pulse at the end of the last stop bit
wr_overflow  out  1  one-clk pulse when a write is dropped

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: tx=1, tx_full=0, tx_empty=1, tx_count=0, tx_busy=0, tx_done_tick=0, wr_overflow=0. FSM goes to IDLE; pointers, tick counter and bit counter are zeroed; FIFO contents are discarded. Reset asserted mid-frame returns tx to 1 at that edge, with no done pulse.
- FIFO write: tx_wr_en with tx_full=0 stores the word and increments the count.
- A write while tx_full=1 is dropped and pulses wr_overflow for one clk. This holds even when a pop happens in the same cycle.
- A write and a pop in the same cycle leave the count unchanged.
- Pointers wrap modulo 2**ADDR_W.
- Flags and tx_count are registered and reflect the state after each edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If tx_empty=0, the next edge pops the FIFO head into the shift register, latches parity_mode and stop2 for the whole frame, enters START and drives tx=0.
  - Latency: a write into an empty FIFO at edge n gives tx=0 after edge n+1.
- Bit timing: the tick counter increments on each clk where s_tick=1. A bit ends on the edge where s_tick=1 and tick counter = OVS-1; the counter then returns to 0. Each bit therefore lasts exactly OVS ticks.
- START (tx=0): after OVS ticks, go to DATA.
- DATA: sends N_BIT bits, LSB first, shifting right after each bit. After bit N_BIT-1, go to PARITY if the latched mode is 01 or 10, otherwise go to STOP.
- PARITY: even mode sends the XOR of the N_BIT data bits; odd mode sends its inverse. Lasts OVS ticks, then STOP.
- STOP (tx=1): lasts OVS ticks, or 2*OVS ticks when stop2 was latched as 1.
  - On the final tick edge, pulse tx_done_tick for one clk and return to IDLE.
- Back-to-back frames: IDLE always lasts at least one clk between frames. If the FIFO is non-empty, START begins on the following edge.
- Changing parity_mode or stop2 mid-frame has no effect until the next frame.
- tx is driven from a register, so it is glitch-free.
- tx_busy = (state != IDLE).

Test Plan:
- Reset: hold rst=1 for 2 clks mid-frame -> tx=1, tx_empty=1, tx_count=0, tx_busy=0, no tx_done_tick.
- Basic frame: N_BIT=8, OVS=16, s_tick every 4 clks; write 0x55 with parity_mode=00, stop2=0 -> tx shows 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks (64 clks); exactly one tx_done_tick; tx_count back to 0.
- Parity and stop bits:
  - write 0x07 with parity_mode=01 -> parity bit = 1.
  - write 0x07 with parity_mode=10 -> parity bit = 0.
  - stop2=1 -> stop level high for 32 ticks before tx_done_tick.
- Overflow (ADDR_W=2): tx_wr_en high for 6 consecutive clks with data 0xA0..0xA5, FSM idle -> the first word is popped while the FIFO fills. Required: tx_full=1 after the 5th write; the 6th write (0xA5) is dropped with one wr_overflow pulse; exactly 5 frames, 0xA0..0xA4, sent in order.
- Config latching: change parity_mode from 01 to 00 during a frame's DATA phase -> that frame still sends its parity bit; the next frame has none.
- Wrap-around and simultaneous write+pop: stream 10 words while keeping tx_count between 1 and 3 -> all words emitted in order, no overflow, tx_count matches writes minus pops every cycle.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// UART transmit path: DEPTH-word write FIFO feeding a serialiser with per-frame parity and stop-bit selection.
// Write to tx low is two clk edges from an empty, idle state; writes into a full FIFO are dropped and flagged.
`timescale 1ns/1ps
module uart_tx_cfg #(
  parameter int N_BIT  = 8,
  parameter int ADDR_W = 2,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tick,
  input  logic [N_BIT-1:0]  tx_wr_data,
  input  logic              tx_wr_en,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              tx,
  output logic              tx_full,
  output logic              tx_empty,
  output logic [ADDR_W:0]   tx_count,
  output logic              tx_busy,
  output logic              tx_done_tick,
  output logic              wr_overflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int TW    = $clog2(OVS);
  localparam int BW    = $clog2(N_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [N_BIT-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_n;
  logic              wr_acc, pop;
  logic [N_BIT-1:0]  head;

  state_t            state, state_n;
  logic [TW-1:0]     tick_cnt, tick_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [N_BIT-1:0]  shreg, sh_n;
  logic              par_en, par_en_n;
  logic              par_bit, par_bit_n;
  logic              stop2_l, stop2_n;
  logic              tx_r, tx_n;
  logic              done_r, done_n;
  logic              tick_last;

  // Full is the registered flag, so a pop in the same cycle does not rescue a write.
  assign wr_acc  = tx_wr_en && !tx_full;
  assign pop     = (state == IDLE) && !tx_empty;
  assign head    = mem[rd_ptr];
  assign count_n = count + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= tx_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_full     <= 1'b0;
      tx_empty    <= 1'b1;
      wr_overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count       <= count_n;
      tx_full     <= (count_n == (ADDR_W+1)'(DEPTH));
      tx_empty    <= (count_n == '0);
      wr_overflow <= tx_wr_en && tx_full;
    end
  end

  assign tx_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2_l  <= 1'b0;
      tx_r     <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
      par_en   <= par_en_n;
      par_bit  <= par_bit_n;
      stop2_l  <= stop2_n;
      tx_r     <= tx_n;
      done_r   <= done_n;
    end
  end

  assign tick_last = s_tick && (tick_cnt == TW'(OVS-1));

  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    sh_n      = shreg;
    par_en_n  = par_en;
    par_bit_n = par_bit;
    stop2_n   = stop2_l;
    tx_n      = tx_r;
    done_n    = 1'b0;
    if (state != IDLE && s_tick) tick_n = tick_last ? '0 : tick_cnt + 1'b1;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        tick_n = '0;
        bit_n  = '0;
        if (!tx_empty) begin
          // Frame configuration is captured here and held until the frame ends.
          sh_n      = head;
          par_en_n  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_n = (parity_mode == 2'b10) ? ~^head : ^head;
          stop2_n   = stop2;
          state_n   = START;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (tick_last) begin
          state_n = DATA;
          tx_n    = shreg[0];
          bit_n   = '0;
        end
      end
      DATA: begin
        if (tick_last) begin
          if (bit_cnt == BW'(N_BIT-1)) begin
            bit_n = '0;
            if (par_en) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            sh_n  = shreg >> 1;
            tx_n  = shreg[1];
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick_last) begin
          state_n = STOP;
          tx_n    = 1'b1;
          bit_n   = '0;
        end
      end
      STOP: begin
        if (tick_last) begin
          // bit_cnt counts completed stop bits in two-stop mode.
          if (stop2_l && bit_cnt == '0) begin
            bit_n = BW'(1);
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx           = tx_r;
  assign tx_busy      = (state != IDLE);
  assign tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame table plus overflow, config-latching, streaming and reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_cfg;
  localparam int N_BIT  = 8;
  localparam int ADDR_W = 2;
  localparam int OVS    = 16;
  localparam int TPB    = 64;

  logic             clk, rst, s_tick, tx_wr_en, stop2;
  logic [7:0]       tx_wr_data;
  logic [1:0]       parity_mode;
  logic             tx, tx_full, tx_empty, tx_busy, tx_done_tick, wr_overflow;
  logic [ADDR_W:0]  tx_count;

  uart_tx_cfg #(.N_BIT(N_BIT), .ADDR_W(ADDR_W), .OVS(OVS)) dut (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_wr_data(tx_wr_data), .tx_wr_en(tx_wr_en),
    .parity_mode(parity_mode), .stop2(stop2), .tx(tx), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_count(tx_count), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .wr_overflow(wr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_tick every 4 clks, changed on the falling edge
  initial begin
    int div;
    div = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      s_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  int busy_ticks = 0, done_cnt = 0, ovf_cnt = 0;
  always @(posedge clk) begin
    if (s_tick && tx_busy) busy_ticks <= busy_ticks + 1;
    if (tx_done_tick)      done_cnt   <= done_cnt + 1;
    if (wr_overflow)       ovf_cnt    <= ovf_cnt + 1;
  end

  // Line receiver: samples tx mid-bit, rx_nbits samples starting with the start bit.
  logic [11:0] rx_q [$];
  int rx_nbits = 10;
  int rx_rd = 0;
  initial begin
    logic [11:0] bits;
    int n;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && rst === 1'b0) begin
        repeat (30) @(negedge clk);
        n = rx_nbits;
        bits = '0;
        for (int i = 0; i < n; i++) begin
          bits[i] = tx;
          if (i != n - 1) repeat (TPB) @(negedge clk);
        end
        rx_q.push_back(bits);
      end
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pmode;
    logic        stop2;
    int          nbits;
    logic [11:0] bits;
  } vec_t;
  vec_t vecs [7];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int n, input string name);
    int c;
    c = 0;
    while ((rx_q.size() - rx_rd) < n && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_frames"}, 32'((rx_q.size() - rx_rd) >= n), 32'd1);
  endtask

  task automatic wait_done(input int target, input string name);
    int c;
    c = 0;
    while (done_cnt < target && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_done"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic next_frame(output logic [11:0] f);
    if (rx_rd < rx_q.size()) begin
      f = rx_q[rx_rd];
      rx_rd++;
    end else begin
      f = 12'hFFF;
    end
  endtask

  task automatic wr1(input logic [7:0] d);
    @(negedge clk);
    tx_wr_en = 1'b1;
    tx_wr_data = d;
    @(negedge clk);
    tx_wr_en = 1'b0;
  endtask

  initial begin
    logic [11:0] f;
    int done0, ovf0, t0, c, sent, exp_cnt;
    bit wr_last, busy_prev, pop;

    vecs[0] = '{8'h55, 2'b00, 1'b0, 10, 12'h2AA};
    vecs[1] = '{8'h07, 2'b01, 1'b0, 11, 12'h60E};
    vecs[2] = '{8'h07, 2'b10, 1'b0, 11, 12'h40E};
    vecs[3] = '{8'hA3, 2'b00, 1'b1, 11, 12'h746};
    vecs[4] = '{8'h3C, 2'b11, 1'b0, 10, 12'h278};
    vecs[5] = '{8'h00, 2'b10, 1'b1, 12, 12'hE00};
    vecs[6] = '{8'hFF, 2'b01, 1'b1, 12, 12'hDFE};

    rst = 1'b1; tx_wr_en = 1'b0; tx_wr_data = '0; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1); chk("rst_full", tx_full, 0); chk("rst_empty", tx_empty, 1);
    chk("rst_count", tx_count, 0); chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done_tick, 0); chk("rst_ovf", wr_overflow, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // First-frame latency and exact bit length
    done0 = done_cnt;
    rx_nbits = 10;
    tx_wr_en = 1'b1; tx_wr_data = 8'h55;
    @(negedge clk);
    tx_wr_en = 1'b0;
    chk("lat_tx_n", tx, 1); chk("lat_count_n", tx_count, 1); chk("lat_empty_n", tx_empty, 0);
    chk("lat_busy_n", tx_busy, 0);
    @(negedge clk);
    chk("lat_tx_n1", tx, 0); chk("lat_busy_n1", tx_busy, 1); chk("lat_count_n1", tx_count, 0);
    c = 0;
    while (tx !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    c = 0;
    while (tx === 1'b1 && c < 200) begin @(negedge clk); c++; end
    chk("bit_len_clks", c, TPB);
    wait_frames(1, "basic");
    wait_done(done0 + 1, "basic");
    next_frame(f);
    chk("basic_bits", f, 12'h2AA);
    chk("basic_done_cnt", done_cnt - done0, 1);
    chk("basic_count", tx_count, 0);

    for (int i = 0; i < 7; i++) begin
      repeat (4) @(negedge clk);
      done0 = done_cnt; t0 = busy_ticks;
      parity_mode = vecs[i].pmode; stop2 = vecs[i].stop2; rx_nbits = vecs[i].nbits;
      wr1(vecs[i].data);
      wait_frames(1, $sformatf("vec%0d", i));
      wait_done(done0 + 1, $sformatf("vec%0d", i));
      repeat (4) @(negedge clk);
      next_frame(f);
      chk($sformatf("vec%0d_bits", i), f, vecs[i].bits);
      chk($sformatf("vec%0d_ticks", i), busy_ticks - t0, OVS * vecs[i].nbits);
      chk($sformatf("vec%0d_done", i), done_cnt - done0, 1);
      chk($sformatf("vec%0d_idle", i), {tx, tx_busy, tx_empty, tx_count}, {1'b1, 1'b0, 1'b1, 3'd0});
    end

    // Parity mode changed during DATA applies only to the following frame
    repeat (4) @(negedge clk);
    done0 = done_cnt;
    parity_mode = 2'b01; stop2 = 1'b0; rx_nbits = 11;
    @(negedge clk);
    tx_wr_en = 1'b1; tx_wr_data = 8'h07;
    @(negedge clk);
    @(negedge clk);
    tx_wr_en = 1'b0;
    repeat (3 * TPB) @(negedge clk);
    parity_mode = 2'b00;
    wait_frames(1, "cfg1");
    rx_nbits = 10;
    wait_frames(2, "cfg2");
    wait_done(done0 + 2, "cfg");
    next_frame(f); chk("cfg_frame1", f, 12'h60E);
    next_frame(f); chk("cfg_frame2", f, 12'h20E);

    // Six back-to-back writes into a depth-4 FIFO
    repeat (4) @(negedge clk);
    done0 = done_cnt; ovf0 = ovf_cnt;
    rx_nbits = 10;
    for (int i = 0; i < 6; i++) begin
      tx_wr_en = 1'b1; tx_wr_data = 8'hA0 + 8'(i);
      @(negedge clk);
      if (i == 3) chk("ovf_full_after4", {tx_full, tx_count}, {1'b0, 3'd3});
      if (i == 4) chk("ovf_full_after5", {tx_full, tx_count}, {1'b1, 3'd4});
      if (i == 5) chk("ovf_pulse", {wr_overflow, tx_count}, {1'b1, 3'd4});
    end
    tx_wr_en = 1'b0;
    @(negedge clk);
    chk("ovf_pulse_end", wr_overflow, 0);
    wait_frames(5, "ovf");
    wait_done(done0 + 5, "ovf");
    repeat (300) @(negedge clk);
    chk("ovf_nframes", rx_q.size() - rx_rd, 5);
    chk("ovf_count", ovf_cnt - ovf0, 1);
    for (int i = 0; i < 5; i++) begin
      next_frame(f);
      chk($sformatf("ovf_word%0d", i), f[8:1], 8'hA0 + 8'(i));
    end

    // Streaming with concurrent write+pop and pointer wrap
    repeat (4) @(negedge clk);
    done0 = done_cnt; ovf0 = ovf_cnt;
    sent = 0; exp_cnt = 0; wr_last = 1'b0; busy_prev = tx_busy;
    c = 0;
    while ((rx_q.size() - rx_rd) < 10 && c < 15000) begin
      @(negedge clk);
      c++;
      pop = tx_busy && !busy_prev;
      busy_prev = tx_busy;
      exp_cnt = exp_cnt + int'(wr_last) - int'(pop);
      chk("stream_count", tx_count, exp_cnt);
      if (sent < 10 && exp_cnt < 3) begin
        tx_wr_en = 1'b1; tx_wr_data = 8'hC0 + 8'(sent * 3);
        sent++; wr_last = 1'b1;
      end else begin
        tx_wr_en = 1'b0; wr_last = 1'b0;
      end
    end
    tx_wr_en = 1'b0;
    chk("stream_frames", rx_q.size() - rx_rd, 10);
    wait_done(done0 + 10, "stream");
    chk("stream_ovf", ovf_cnt - ovf0, 0);
    for (int i = 0; i < 10; i++) begin
      next_frame(f);
      chk($sformatf("stream_word%0d", i), f[8:1], 8'hC0 + 8'(i * 3));
    end

    // Reset in the middle of a frame with a word still queued
    repeat (4) @(negedge clk);
    done0 = done_cnt;
    wr1(8'h12);
    wr1(8'h34);
    repeat (200) @(negedge clk);
    chk("mid_busy_pre", tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    @(negedge clk);
    chk("mid_rst_state", {tx, tx_busy, tx_empty, tx_count, tx_full}, {1'b1, 1'b0, 1'b1, 3'd0, 1'b0});
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("mid_rst_after", {tx, tx_busy, tx_empty}, {1'b1, 1'b0, 1'b1});
    chk("mid_rst_nodone", done_cnt - done0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
